// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and funct3 encodings for the memory stage
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [2:0] {
    IDLE,
    LD_REQ,
    LD_WAIT,
    LD_HOLD,
    LD_KILL
  } ld_state_e;

  // Sized for the widest datapath (XLEN=64); narrower builds use the low bits.
  typedef struct packed {
    logic [63:0] addr;
    logic [7:0]  be;
    logic [63:0] wdata;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - posted-store FIFO; pointers carry a wrap bit for full/empty
module store_buffer
  import mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk_i,
  input  logic      reset_i,
  input  logic      push_i,
  input  sb_entry_t push_data_i,
  input  logic      pop_i,
  output sb_entry_t head_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int AW = $clog2(DEPTH);

  sb_entry_t   mem_q [DEPTH];
  logic [AW:0] wr_q;
  logic [AW:0] rd_q;
  logic        do_push;
  logic        do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/mem_stage_sb.sv
// rtl/mem_stage_sb.sv - memory stage: sized loads/stores, posted-store buffer, load FSM
module mem_stage_sb
  import mem_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int SB_DEPTH = 4,
  parameter int SEL_W    = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               icache_stall,
  input  logic               flush,
  input  logic               ac_valid,
  input  logic [XLEN-1:0]    ac_pc,
  input  logic [SEL_W-1:0]   ac_write_sel,
  input  logic [XLEN-1:0]    ac_alu_result,
  input  logic [XLEN-1:0]    ac_data2,
  input  logic [2:0]         ac_funct3,
  input  logic               ac_is_load,
  input  logic               ac_is_store,
  input  logic               ac_is_wb,
  output logic               dc_req_valid,
  input  logic               dc_req_ready,
  output logic               dc_req_we,
  output logic [XLEN-1:0]    dc_req_addr,
  output logic [XLEN-1:0]    dc_req_wdata,
  output logic [XLEN/8-1:0]  dc_req_be,
  input  logic               dc_resp_valid,
  input  logic [XLEN-1:0]    dc_resp_rdata,
  output logic               cw_valid,
  output logic [XLEN-1:0]    cw_pc,
  output logic [SEL_W-1:0]   cw_write_sel,
  output logic [XLEN-1:0]    cw_result,
  output logic               cw_is_wb,
  output logic               cw_misalign,
  output logic               mem_stall
);

  localparam int BE_W  = XLEN / 8;
  localparam int OFF_W = $clog2(BE_W);

  ld_state_e state_q, state_d;
  logic [1:0] sz;
  logic legal, aligned, misal, accept, ld_go, pop, wb_ld;
  logic sb_full, sb_empty;
  logic [BE_W-1:0] st_be;
  logic [XLEN-1:0] st_wdata, ld_ext;
  logic [OFF_W-1:0] off;
  sb_entry_t push_entry, sb_head;

  logic [XLEN-1:0]  ld_pc_q, ld_addr_q, ld_data_q;
  logic [SEL_W-1:0] ld_sel_q;
  logic [2:0]       ld_f3_q;
  logic             ld_wb_q;
  logic             cw_valid_q, cw_is_wb_q, cw_misalign_q;
  logic [XLEN-1:0]  cw_pc_q, cw_result_q;
  logic [SEL_W-1:0] cw_sel_q;

  function automatic logic [XLEN-1:0] ld_extend(input logic [XLEN-1:0] word,
                                                input logic [OFF_W-1:0] lane,
                                                input logic [2:0] f3);
    logic [XLEN-1:0] s;
    s = word >> {lane, 3'b000};
    case (f3)
      F3_B:    ld_extend = XLEN'(signed'(s[7:0]));
      F3_H:    ld_extend = XLEN'(signed'(s[15:0]));
      F3_W:    ld_extend = XLEN'(signed'(s[31:0]));
      F3_BU:   ld_extend = XLEN'(s[7:0]);
      F3_HU:   ld_extend = XLEN'(s[15:0]);
      F3_WU:   ld_extend = XLEN'(s[31:0]);
      default: ld_extend = s;
    endcase
  endfunction

  assign off = ac_alu_result[OFF_W-1:0];

  // Unsupported funct3 codes take the misalignment path as an exception.
  always_comb begin
    sz    = 2'd0;
    legal = 1'b0;
    case (ac_funct3)
      F3_B:    begin sz = 2'd0; legal = 1'b1; end
      F3_H:    begin sz = 2'd1; legal = 1'b1; end
      F3_W:    begin sz = 2'd2; legal = 1'b1; end
      F3_D:    begin sz = 2'd3; legal = (XLEN == 64); end
      F3_BU:   begin sz = 2'd0; legal = ac_is_load; end
      F3_HU:   begin sz = 2'd1; legal = ac_is_load; end
      F3_WU:   begin sz = 2'd2; legal = ac_is_load && (XLEN == 64); end
      default: ;
    endcase
    case (sz)
      2'd0:    aligned = 1'b1;
      2'd1:    aligned = !ac_alu_result[0];
      2'd2:    aligned = (ac_alu_result[1:0] == 2'b00);
      default: aligned = (ac_alu_result[2:0] == 3'b000);
    endcase
    misal = (ac_is_load || ac_is_store) && !(legal && aligned);
  end

  always_comb begin
    case (sz)
      2'd0:    begin st_be = BE_W'(1) << off;  st_wdata = {BE_W{ac_data2[7:0]}}; end
      2'd1:    begin st_be = BE_W'(3) << off;  st_wdata = {(BE_W/2){ac_data2[15:0]}}; end
      2'd2:    begin st_be = BE_W'(15) << off; st_wdata = {(XLEN/32){ac_data2[31:0]}}; end
      default: begin st_be = '1;               st_wdata = ac_data2; end
    endcase
  end

  assign accept = ac_valid && !mem_stall && !icache_stall && !flush;
  assign ld_go  = accept && ac_is_load && !misal;
  assign push_entry = '{addr:  64'({ac_alu_result[XLEN-1:OFF_W], {OFF_W{1'b0}}}),
                        be:    8'(st_be),
                        wdata: 64'(st_wdata)};

  store_buffer #(.DEPTH(SB_DEPTH)) u_sb (
    .clk_i       (clock),
    .reset_i     (reset),
    .push_i      (accept && ac_is_store && !misal),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (sb_head),
    .full_o      (sb_full),
    .empty_o     (sb_empty)
  );

  assign ld_ext = ld_extend(dc_resp_rdata, ld_addr_q[OFF_W-1:0], ld_f3_q);

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ld_go) state_d = LD_REQ;
      LD_REQ:  if (flush) state_d = IDLE;
               else if (dc_req_ready) state_d = LD_WAIT;
      // A response coinciding with flush is consumed here, so LD_KILL never waits on it.
      LD_WAIT: if (flush) state_d = dc_resp_valid ? IDLE : LD_KILL;
               else if (dc_resp_valid) state_d = icache_stall ? LD_HOLD : IDLE;
      LD_HOLD: if (flush || !icache_stall) state_d = IDLE;
      LD_KILL: if (dc_resp_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dc_req_valid = 1'b0;
    dc_req_we    = 1'b0;
    dc_req_addr  = '0;
    dc_req_wdata = '0;
    dc_req_be    = '0;
    pop          = 1'b0;
    if (!reset) begin
      case (state_q)
        IDLE: if (!sb_empty) begin
          dc_req_valid = 1'b1;
          dc_req_we    = 1'b1;
          dc_req_addr  = XLEN'(sb_head.addr);
          dc_req_wdata = XLEN'(sb_head.wdata);
          dc_req_be    = BE_W'(sb_head.be);
          pop          = dc_req_ready;
        end
        LD_REQ: begin
          dc_req_valid = !flush;
          dc_req_addr  = {ld_addr_q[XLEN-1:OFF_W], {OFF_W{1'b0}}};
          dc_req_be    = '1;
        end
        default: ;
      endcase
    end
    mem_stall = (state_q != IDLE)
              || (ac_valid && ac_is_store && sb_full && !pop)
              || (ac_valid && ac_is_load && !sb_empty);
  end

  assign wb_ld = !flush && !icache_stall &&
                 ((state_q == LD_WAIT && dc_resp_valid) || state_q == LD_HOLD);

  always_ff @(posedge clock) begin
    if (reset) begin
      {ld_pc_q, ld_addr_q, ld_data_q, ld_sel_q, ld_f3_q, ld_wb_q} <= '0;
      {cw_valid_q, cw_is_wb_q, cw_misalign_q, cw_pc_q, cw_result_q, cw_sel_q} <= '0;
    end else begin
      if (ld_go) begin
        ld_pc_q   <= ac_pc;
        ld_addr_q <= ac_alu_result;
        ld_sel_q  <= ac_write_sel;
        ld_f3_q   <= ac_funct3;
        ld_wb_q   <= ac_is_wb;
      end
      if (state_q == LD_WAIT && dc_resp_valid && !flush && icache_stall) ld_data_q <= ld_ext;
      if (!icache_stall) begin
        if (wb_ld) begin
          cw_valid_q    <= 1'b1;
          cw_pc_q       <= ld_pc_q;
          cw_sel_q      <= ld_sel_q;
          cw_result_q   <= (state_q == LD_HOLD) ? ld_data_q : ld_ext;
          cw_is_wb_q    <= ld_wb_q;
          cw_misalign_q <= 1'b0;
        end else if (accept && !ld_go) begin
          cw_valid_q    <= 1'b1;
          cw_pc_q       <= ac_pc;
          cw_sel_q      <= ac_write_sel;
          cw_result_q   <= ac_alu_result;
          cw_is_wb_q    <= ac_is_wb && !misal;
          cw_misalign_q <= misal;
        end else begin
          cw_valid_q    <= 1'b0;
          cw_is_wb_q    <= 1'b0;
          cw_misalign_q <= 1'b0;
        end
      end
    end
  end

  assign cw_valid     = cw_valid_q;
  assign cw_pc        = cw_pc_q;
  assign cw_write_sel = cw_sel_q;
  assign cw_result    = cw_result_q;
  assign cw_is_wb     = cw_is_wb_q;
  assign cw_misalign  = cw_misalign_q;

endmodule

// File: tb/tb_mem_stage_sb.sv
// tb/tb_mem_stage_sb.sv - directed vector bench for mem_stage_sb (XLEN=32, SB_DEPTH=4)
module tb_mem_stage_sb;

  localparam int XLEN  = 32;
  localparam int SEL_W = 5;
  localparam int BE_W  = 4;

  logic             clock = 1'b0;
  logic             reset, icache_stall, flush;
  logic             ac_valid, ac_is_load, ac_is_store, ac_is_wb;
  logic [XLEN-1:0]  ac_pc, ac_alu_result, ac_data2;
  logic [SEL_W-1:0] ac_write_sel;
  logic [2:0]       ac_funct3;
  logic             dc_req_valid, dc_req_ready, dc_req_we;
  logic [XLEN-1:0]  dc_req_addr, dc_req_wdata;
  logic [BE_W-1:0]  dc_req_be;
  logic             dc_resp_valid;
  logic [XLEN-1:0]  dc_resp_rdata;
  logic             cw_valid, cw_is_wb, cw_misalign, mem_stall;
  logic [XLEN-1:0]  cw_pc, cw_result;
  logic [SEL_W-1:0] cw_write_sel;

  mem_stage_sb #(.XLEN(XLEN), .SB_DEPTH(4), .SEL_W(SEL_W)) dut (
    .clock(clock), .reset(reset), .icache_stall(icache_stall), .flush(flush),
    .ac_valid(ac_valid), .ac_pc(ac_pc), .ac_write_sel(ac_write_sel),
    .ac_alu_result(ac_alu_result), .ac_data2(ac_data2), .ac_funct3(ac_funct3),
    .ac_is_load(ac_is_load), .ac_is_store(ac_is_store), .ac_is_wb(ac_is_wb),
    .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_we(dc_req_we),
    .dc_req_addr(dc_req_addr), .dc_req_wdata(dc_req_wdata), .dc_req_be(dc_req_be),
    .dc_resp_valid(dc_resp_valid), .dc_resp_rdata(dc_resp_rdata),
    .cw_valid(cw_valid), .cw_pc(cw_pc), .cw_write_sel(cw_write_sel),
    .cw_result(cw_result), .cw_is_wb(cw_is_wb), .cw_misalign(cw_misalign),
    .mem_stall(mem_stall)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] d2;
    logic [31:0] rdata;
    logic [31:0] res;
    logic        mis;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] ra;
  } vec_t;

  vec_t vecs [16];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic present(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] d2, input logic [31:0] pc);
    ac_valid = 1'b1; ac_is_load = ld; ac_is_store = st; ac_is_wb = !st;
    ac_funct3 = f3; ac_alu_result = addr; ac_data2 = d2; ac_pc = pc; ac_write_sel = 5'd7;
  endtask

  task automatic drop();
    ac_valid = 1'b0; ac_is_load = 1'b0; ac_is_store = 1'b0; ac_is_wb = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int i);
    logic [31:0] pc;
    pc = 32'h8000_0000 + 32'(i * 4);
    present(v.ld, v.st, v.f3, v.addr, v.d2, pc);
    #1;
    chk($sformatf("v%0d.stall_in", i), mem_stall, 0);
    if (v.mis) chk($sformatf("v%0d.no_req", i), dc_req_valid, 0);
    tick();
    drop();
    #1;
    if (v.mis || (!v.ld && !v.st)) begin
      chk($sformatf("v%0d.cw_valid", i), cw_valid, 1);
      chk($sformatf("v%0d.misalign", i), cw_misalign, v.mis);
      chk($sformatf("v%0d.is_wb", i), cw_is_wb, !v.mis);
      chk($sformatf("v%0d.pc", i), cw_pc, pc);
      if (!v.mis) chk($sformatf("v%0d.result", i), cw_result, v.res);
      chk($sformatf("v%0d.no_req_after", i), dc_req_valid, 0);
    end else if (v.st) begin
      chk($sformatf("v%0d.cw_valid", i), cw_valid, 1);
      chk($sformatf("v%0d.is_wb", i), cw_is_wb, 0);
      chk($sformatf("v%0d.req_valid", i), dc_req_valid, 1);
      chk($sformatf("v%0d.we", i), dc_req_we, 1);
      chk($sformatf("v%0d.addr", i), dc_req_addr, v.ra);
      chk($sformatf("v%0d.be", i), dc_req_be, v.be);
      chk($sformatf("v%0d.wdata", i), dc_req_wdata, v.wd);
      dc_req_ready = 1'b1;
      tick();
      dc_req_ready = 1'b0;
      #1;
      chk($sformatf("v%0d.drained", i), dc_req_valid, 0);
    end else begin
      chk($sformatf("v%0d.bubble", i), cw_valid, 0);
      chk($sformatf("v%0d.req_valid", i), dc_req_valid, 1);
      chk($sformatf("v%0d.we", i), dc_req_we, 0);
      chk($sformatf("v%0d.be", i), dc_req_be, 4'hF);
      chk($sformatf("v%0d.addr", i), dc_req_addr, v.ra);
      dc_req_ready = 1'b1;
      tick();
      dc_req_ready = 1'b0;
      dc_resp_valid = 1'b1;
      dc_resp_rdata = v.rdata;
      tick();
      dc_resp_valid = 1'b0;
      #1;
      chk($sformatf("v%0d.cw_valid", i), cw_valid, 1);
      chk($sformatf("v%0d.result", i), cw_result, v.res);
      chk($sformatf("v%0d.pc", i), cw_pc, pc);
      chk($sformatf("v%0d.sel", i), cw_write_sel, 5'd7);
      chk($sformatf("v%0d.is_wb", i), cw_is_wb, 1);
      chk($sformatf("v%0d.stall_out", i), mem_stall, 0);
    end
  endtask

  initial begin
    //            ld st f3      addr           d2             rdata          res            mis be     wd             ra
    vecs[0]  = '{0, 0, 3'b000, 32'h0000_1234, 32'h0,         32'h0,         32'h0000_1234, 0, 4'h0, 32'h0,         32'h0};
    vecs[1]  = '{0, 1, 3'b000, 32'h0000_0103, 32'h0000_00AB, 32'h0,         32'h0,         0, 4'h8, 32'hABAB_ABAB, 32'h0000_0100};
    vecs[2]  = '{0, 1, 3'b001, 32'h0000_0202, 32'h1234_BEEF, 32'h0,         32'h0,         0, 4'hC, 32'hBEEF_BEEF, 32'h0000_0200};
    vecs[3]  = '{0, 1, 3'b010, 32'h0000_0308, 32'hDEAD_BEEF, 32'h0,         32'h0,         0, 4'hF, 32'hDEAD_BEEF, 32'h0000_0308};
    vecs[4]  = '{0, 1, 3'b000, 32'h0000_0101, 32'h0000_005A, 32'h0,         32'h0,         0, 4'h2, 32'h5A5A_5A5A, 32'h0000_0100};
    vecs[5]  = '{1, 0, 3'b000, 32'h0000_0002, 32'h0,         32'h0080_0000, 32'hFFFF_FF80, 0, 4'h0, 32'h0,         32'h0};
    vecs[6]  = '{1, 0, 3'b100, 32'h0000_0002, 32'h0,         32'h0080_0000, 32'h0000_0080, 0, 4'h0, 32'h0,         32'h0};
    vecs[7]  = '{1, 0, 3'b001, 32'h0000_0006, 32'h0,         32'h8001_0000, 32'hFFFF_8001, 0, 4'h0, 32'h0,         32'h0000_0004};
    vecs[8]  = '{1, 0, 3'b101, 32'h0000_0006, 32'h0,         32'h8001_0000, 32'h0000_8001, 0, 4'h0, 32'h0,         32'h0000_0004};
    vecs[9]  = '{1, 0, 3'b010, 32'h0000_0008, 32'h0,         32'hCAFE_F00D, 32'hCAFE_F00D, 0, 4'h0, 32'h0,         32'h0000_0008};
    vecs[10] = '{1, 0, 3'b000, 32'h0000_0003, 32'h0,         32'h7F00_0000, 32'h0000_007F, 0, 4'h0, 32'h0,         32'h0};
    vecs[11] = '{1, 0, 3'b010, 32'h0000_0006, 32'h0,         32'h0,         32'h0,         1, 4'h0, 32'h0,         32'h0};
    vecs[12] = '{1, 0, 3'b001, 32'h0000_0001, 32'h0,         32'h0,         32'h0,         1, 4'h0, 32'h0,         32'h0};
    vecs[13] = '{1, 0, 3'b011, 32'h0000_0000, 32'h0,         32'h0,         32'h0,         1, 4'h0, 32'h0,         32'h0};
    vecs[14] = '{0, 1, 3'b100, 32'h0000_0000, 32'h0000_0011, 32'h0,         32'h0,         1, 4'h0, 32'h0,         32'h0};
    vecs[15] = '{1, 0, 3'b110, 32'h0000_0000, 32'h0,         32'h0,         32'h0,         1, 4'h0, 32'h0,         32'h0};

    drop();
    icache_stall = 1'b0; flush = 1'b0; dc_req_ready = 1'b0; dc_resp_valid = 1'b0;
    dc_resp_rdata = '0; ac_pc = '0; ac_alu_result = '0; ac_data2 = '0;
    ac_funct3 = 3'b000; ac_write_sel = '0;
    reset = 1'b1;
    tick();
    tick();
    chk("reset.cw_valid", cw_valid, 0);
    chk("reset.cw_result", cw_result, 0);
    chk("reset.cw_is_wb", cw_is_wb, 0);
    chk("reset.req_valid", dc_req_valid, 0);
    chk("reset.mem_stall", mem_stall, 0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

    // Five stores into a four-entry buffer with the dcache refusing.
    for (int k = 0; k < 4; k++) begin
      present(0, 1, 3'b010, 32'h40 + 32'(k * 4), 32'hA0A0_0000 + 32'(k), 32'h100);
      #1;
      chk($sformatf("burst.no_stall%0d", k), mem_stall, 0);
      tick();
    end
    present(0, 1, 3'b010, 32'h50, 32'hA0A0_0004, 32'h100);
    #1;
    chk("burst.full_stall", mem_stall, 1);
    tick();
    chk("burst.still_stall", mem_stall, 1);
    dc_req_ready = 1'b1;
    #1;
    chk("burst.push_pop", mem_stall, 0);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("burst.valid%0d", k), dc_req_valid, 1);
      chk($sformatf("burst.addr%0d", k), dc_req_addr, 32'h40 + 32'(k * 4));
      chk($sformatf("burst.data%0d", k), dc_req_wdata, 32'hA0A0_0000 + 32'(k));
      tick();
      drop();
    end
    dc_req_ready = 1'b0;
    #1;
    chk("burst.empty", dc_req_valid, 0);

    // Load behind a buffered store waits for the drain.
    present(0, 1, 3'b010, 32'h80, 32'h1111_2222, 32'h200);
    tick();
    present(1, 0, 3'b010, 32'h84, 32'h0, 32'h204);
    #1;
    chk("order.load_wait", mem_stall, 1);
    dc_req_ready = 1'b1;
    tick();
    dc_req_ready = 1'b0;
    #1;
    chk("order.released", mem_stall, 0);
    tick();
    drop();
    #1;
    chk("order.ld_req", dc_req_we, 0);
    chk("order.ld_addr", dc_req_addr, 32'h84);
    dc_req_ready = 1'b1;
    tick();
    dc_req_ready = 1'b0;
    dc_resp_valid = 1'b1;
    dc_resp_rdata = 32'h5555_AAAA;
    tick();
    dc_resp_valid = 1'b0;
    #1;
    chk("order.result", cw_result, 32'h5555_AAAA);

    // Flush in LD_WAIT; the response two cycles later is discarded.
    present(1, 0, 3'b000, 32'h10, 32'h0, 32'h300);
    tick();
    drop();
    dc_req_ready = 1'b1;
    tick();
    dc_req_ready = 1'b0;
    flush = 1'b1;
    #1;
    chk("kill.stall_wait", mem_stall, 1);
    tick();
    flush = 1'b0;
    #1;
    chk("kill.stall_kill", mem_stall, 1);
    chk("kill.cw_valid", cw_valid, 0);
    tick();
    dc_resp_valid = 1'b1;
    dc_resp_rdata = 32'h1234_5678;
    tick();
    dc_resp_valid = 1'b0;
    #1;
    chk("kill.discarded", cw_valid, 0);
    chk("kill.idle", mem_stall, 0);
    present(0, 0, 3'b000, 32'h55, 32'h0, 32'h304);
    tick();
    drop();
    #1;
    chk("kill.next_alu", cw_result, 32'h55);

    // Response under icache_stall is held until the first free cycle.
    present(1, 0, 3'b010, 32'h20, 32'h0, 32'h400);
    tick();
    drop();
    dc_req_ready = 1'b1;
    tick();
    dc_req_ready = 1'b0;
    icache_stall = 1'b1;
    dc_resp_valid = 1'b1;
    dc_resp_rdata = 32'h1122_3344;
    tick();
    dc_resp_valid = 1'b0;
    #1;
    chk("hold.frozen", cw_valid, 0);
    chk("hold.stall", mem_stall, 1);
    tick();
    chk("hold.frozen2", cw_valid, 0);
    icache_stall = 1'b0;
    tick();
    chk("hold.cw_valid", cw_valid, 1);
    chk("hold.result", cw_result, 32'h1122_3344);
    chk("hold.pc", cw_pc, 32'h400);
    chk("hold.idle", mem_stall, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
